// File: rtl/uart_rx_fifo_if.sv
// System-side bundle of the UART receive FIFO: head-of-queue data, pop
// handshake, occupancy and sticky error flags.
// master: the receiver (drives data and status).
// slave:  the consuming core (drives pop and error clear).
interface uart_rx_fifo_if #(
    parameter int fifo_depth = 16
);
    localparam int COUNT_W = $clog2(fifo_depth) + 1;

    logic [7:0]         rx_data;
    logic               rx_avail;
    logic               rx_ack;
    logic [COUNT_W-1:0] rx_count;
    logic               frame_err;
    logic               overrun;
    logic               err_clr;

    modport master (
        output rx_data,
        output rx_avail,
        output rx_count,
        output frame_err,
        output overrun,
        input  rx_ack,
        input  err_clr
    );

    modport slave (
        input  rx_data,
        input  rx_avail,
        input  rx_count,
        input  frame_err,
        input  overrun,
        output rx_ack,
        output err_clr
    );
endinterface

// File: rtl/uart_rx_fifo.sv
// UART 8N1 receiver feeding a first-word-fall-through FIFO.
// The serial line passes a two-flop synchroniser, a mid-bit sampling FSM
// recovers each byte, and good bytes are queued for the system core.
// Framing and overrun errors are sticky until err_clr.
//
// Optional build macro UART_RX_MAJORITY_EN: every start/data/stop sample
// becomes a 2-of-3 vote over the cycles around the nominal centre, with the
// decision one cycle after the centre. Needs DIV >= 4.
module uart_rx_fifo #(
    parameter int clk_freq       = 50000000,
    parameter int uart_baud_rate = 1152000,
    parameter int fifo_depth     = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               uart_rxd,
    uart_rx_fifo_if.master     sys
);
    localparam int DIV     = clk_freq / uart_baud_rate;
    localparam int HALF    = DIV / 2;
    localparam int CNT_W   = $clog2(DIV);
    localparam int PTR_W   = $clog2(fifo_depth);
    localparam int COUNT_W = PTR_W + 1;

    localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(DIV - 1);
    localparam logic [COUNT_W-1:0] FULL_CNT = COUNT_W'(fifo_depth);

    // ------------------------------------------------------------------
    // Input synchroniser; presets to the idle (high) line level.
    // ------------------------------------------------------------------
    logic sync1_reg;
    logic rxd_s;

    // Two-flop synchroniser for the asynchronous serial input.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1_reg <= 1'b1;
            rxd_s     <= 1'b1;
        end else begin
            sync1_reg <= uart_rxd;
            rxd_s     <= sync1_reg;
        end
    end

    // ------------------------------------------------------------------
    // Bit decision value and sampling positions.
    // ------------------------------------------------------------------
    logic bit_val;

`ifdef UART_RX_MAJORITY_EN
    // The vote is taken one cycle after the nominal centre. The start
    // decision restarts the counter at 1 so the data-bit counter stays in
    // phase with the nominal centres; data/stop decisions then land where
    // the free-running counter has just wrapped to 0.
    localparam logic [CNT_W-1:0] START_AT   = CNT_W'(HALF);
    localparam logic [CNT_W-1:0] START_NEXT = CNT_W'(1);
    localparam logic [CNT_W-1:0] BIT_AT     = '0;

    logic hist1_reg;
    logic hist2_reg;

    // Two-deep history of the synchronised line for the 2-of-3 vote.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hist1_reg <= 1'b1;
            hist2_reg <= 1'b1;
        end else begin
            hist1_reg <= rxd_s;
            hist2_reg <= hist1_reg;
        end
    end

    assign bit_val = (hist2_reg & hist1_reg) | (hist1_reg & rxd_s) | (hist2_reg & rxd_s);
`else
    // Single sample exactly at the nominal centre.
    localparam logic [CNT_W-1:0] START_AT   = CNT_W'(HALF - 1);
    localparam logic [CNT_W-1:0] START_NEXT = '0;
    localparam logic [CNT_W-1:0] BIT_AT     = CNT_LAST;

    assign bit_val = rxd_s;
`endif

    // ------------------------------------------------------------------
    // Frame recovery FSM.
    // ------------------------------------------------------------------
    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        BREAK
    } state_t;

    state_t           state_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic [CNT_W-1:0] cnt_wrap;
    logic [2:0]       bit_idx_reg;
    logic [7:0]       shift_reg;
    logic             push_reg;
    logic             frame_err_reg;

    // Bit-period counter runs 0..DIV-1 and wraps during data and stop bits.
    assign cnt_wrap = (cnt_reg == CNT_LAST) ? '0 : cnt_reg + CNT_W'(1);

    // Receive FSM: start validation, LSB-first shift, stop check, break wait.
    // push_reg is a one-cycle strobe to the FIFO; frame_err is sticky here.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg     <= IDLE;
            cnt_reg       <= '0;
            bit_idx_reg   <= '0;
            shift_reg     <= '0;
            push_reg      <= 1'b0;
            frame_err_reg <= 1'b0;
        end else begin
            push_reg <= 1'b0;
            // A new framing error below overrides the clear.
            if (sys.err_clr) begin
                frame_err_reg <= 1'b0;
            end
            case (state_reg)
                IDLE: begin
                    if (!rxd_s) begin
                        state_reg <= START;
                        cnt_reg   <= '0;
                    end
                end
                START: begin
                    if (cnt_reg == START_AT) begin
                        if (bit_val) begin
                            // Too short to be a start bit: treat as a glitch.
                            state_reg <= IDLE;
                        end else begin
                            state_reg   <= DATA;
                            cnt_reg     <= START_NEXT;
                            bit_idx_reg <= '0;
                        end
                    end else begin
                        cnt_reg <= cnt_reg + CNT_W'(1);
                    end
                end
                DATA: begin
                    cnt_reg <= cnt_wrap;
                    if (cnt_reg == BIT_AT) begin
                        shift_reg   <= {bit_val, shift_reg[7:1]};
                        bit_idx_reg <= bit_idx_reg + 3'd1;
                        if (bit_idx_reg == 3'd7) begin
                            state_reg <= STOP;
                        end
                    end
                end
                STOP: begin
                    cnt_reg <= cnt_wrap;
                    if (cnt_reg == BIT_AT) begin
                        if (bit_val) begin
                            push_reg  <= 1'b1;
                            state_reg <= IDLE;
                        end else begin
                            frame_err_reg <= 1'b1;
                            state_reg     <= BREAK;
                        end
                    end
                end
                BREAK: begin
                    // Hold off until the line returns high so a long break
                    // reports only one framing error.
                    if (rxd_s) begin
                        state_reg <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // First-word-fall-through FIFO.
    // ------------------------------------------------------------------
    logic [7:0]         mem [fifo_depth];
    logic [PTR_W-1:0]   wr_ptr_reg;
    logic [PTR_W-1:0]   rd_ptr_reg;
    logic [COUNT_W-1:0] count_reg;
    logic               overrun_reg;
    logic               full;
    logic               pop;
    logic               push_ok;

    assign full = (count_reg == FULL_CNT);
    assign pop  = sys.rx_ack && (count_reg != '0);
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    assign push_ok = push_reg && (!full || pop);

    // Storage write; contents need no reset because occupancy gates reads.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr_reg] <= shift_reg;
        end
    end

    // Pointers, occupancy and the sticky overrun flag.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_reg  <= '0;
            rd_ptr_reg  <= '0;
            count_reg   <= '0;
            overrun_reg <= 1'b0;
        end else begin
            if (push_ok) begin
                wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
            end
            case ({push_ok, pop})
                2'b10:   count_reg <= count_reg + COUNT_W'(1);
                2'b01:   count_reg <= count_reg - COUNT_W'(1);
                default: count_reg <= count_reg;
            endcase
            if (push_reg && full && !pop) begin
                overrun_reg <= 1'b1;
            end else if (sys.err_clr) begin
                overrun_reg <= 1'b0;
            end
        end
    end

    assign sys.rx_avail  = (count_reg != '0);
    assign sys.rx_data   = sys.rx_avail ? mem[rd_ptr_reg] : 8'h00;
    assign sys.rx_count  = count_reg;
    assign sys.frame_err = frame_err_reg;
    assign sys.overrun   = overrun_reg;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Testbench for uart_rx_fifo: 8N1 frame generator, queue-based reference
// FIFO, and an independent monitor that pops and compares head bytes.
module tb_uart_rx_fifo;
    localparam int DEPTH     = 16;
    localparam int DIV       = 50000000 / 1152000;   // 43
    localparam int HALF      = DIV / 2;              // 21
    localparam int FRAME_CYC = 10 * DIV;
`ifdef UART_RX_MAJORITY_EN
    localparam int DECIDE_LAG = 1;
`else
    localparam int DECIDE_LAG = 0;
`endif
    // Frame cycle index c counts falling clock edges after the start bit is
    // driven. Two synchroniser flops plus the IDLE detect edge precede the
    // start counter, then HALF + 9*DIV cycles reach the stop decision.
    localparam int STOP_C = 3 + HALF + 9 * DIV + DECIDE_LAG;
    localparam int PUSH_C = STOP_C + 1;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic rxd = 1'b1;

    always #10 clk = ~clk;

    uart_rx_fifo_if #(.fifo_depth(DEPTH)) sys_if ();

    uart_rx_fifo #(
        .clk_freq       (50000000),
        .uart_baud_rate (1152000),
        .fifo_depth     (DEPTH)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .uart_rxd (rxd),
        .sys      (sys_if)
    );

    int         checks = 0;
    int         errors = 0;
    logic [7:0] model_q [$];
    logic       exp_frame_err = 1'b0;
    logic       exp_overrun   = 1'b0;
    logic       mon_en        = 1'b0;
    logic       ack_req       = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference FIFO: bounded queue; a byte arriving when full is lost.
    task automatic model_push(input logic [7:0] d);
        if (model_q.size() < DEPTH) begin
            model_q.push_back(d);
        end else begin
            exp_overrun = 1'b1;
        end
    endtask

    // Monitor: pops whenever data is shown and a pop is wanted, checks the
    // head against the reference queue, and drives rx_ack for the next edge.
    always @(negedge clk) begin
        #1;
        if (rst && sys_if.rx_avail &&
            (ack_req || (mon_en && ($urandom_range(0, 2) == 0)))) begin
            if (model_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL pop_unexpected: got 0x%0h expected none", sys_if.rx_data);
            end else begin
                check("pop_data", {24'h0, sys_if.rx_data}, {24'h0, model_q.pop_front()});
            end
            sys_if.rx_ack = 1'b1;
        end else begin
            sys_if.rx_ack = 1'b0;
        end
    end

    // One 8N1 frame; glitch forces the line low for one cycle at that index.
    task automatic send_frame(input logic [7:0] d, input logic stop_ok, input int glitch);
        int   b;
        logic lvl;
        @(negedge clk);
        for (int c = 0; c < FRAME_CYC; c++) begin
            b = c / DIV;
            if (b == 0)      lvl = 1'b0;
            else if (b <= 8) lvl = d[b-1];
            else             lvl = stop_ok;
            if (c == glitch) lvl = 1'b0;
            rxd = lvl;
            if (c == PUSH_C) begin
                if (stop_ok) model_push(d);
                else         exp_frame_err = 1'b1;
            end
            @(negedge clk);
        end
    endtask

    task automatic idle(input int n);
        rxd = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    task automatic pop_one();
        ack_req = 1'b1;
        @(negedge clk);
        ack_req = 1'b0;
        @(negedge clk);
    endtask

    task automatic clear_errors();
        sys_if.err_clr = 1'b1;
        @(negedge clk);
        sys_if.err_clr = 1'b0;
        exp_frame_err = 1'b0;
        exp_overrun   = 1'b0;
        @(negedge clk);
    endtask

    // Let the monitor empty the FIFO, bounded in cycles.
    task automatic drain(input string name);
        mon_en = 1'b1;
        for (int i = 0; i < 400 && (model_q.size() != 0 || sys_if.rx_avail); i++) begin
            @(negedge clk);
        end
        mon_en = 1'b0;
        check({name, "_count"}, {27'h0, sys_if.rx_count}, 32'd0);
        check({name, "_model"}, model_q.size(), 32'd0);
    endtask

    task automatic check_status(input string name);
        check({name, "_count"}, {27'h0, sys_if.rx_count}, model_q.size());
        check({name, "_frame_err"}, {31'h0, sys_if.frame_err}, {31'h0, exp_frame_err});
        check({name, "_overrun"}, {31'h0, sys_if.overrun}, {31'h0, exp_overrun});
    endtask

    initial begin
        sys_if.err_clr = 1'b0;
        rst = 1'b0;
        rxd = 1'b1;
        repeat (3) @(negedge clk);

        // Reset state
        check("rst_avail", {31'h0, sys_if.rx_avail}, 32'd0);
        check("rst_data", {24'h0, sys_if.rx_data}, 32'd0);
        check_status("rst");
        rst = 1'b1;
        idle(5);

        // Single byte and exact push latency
        fork
            send_frame(8'hA5, 1'b1, -1);
            begin
                @(negedge clk);
                repeat (PUSH_C - 1) @(negedge clk);
                check("t1_avail_at_stop", {31'h0, sys_if.rx_avail}, 32'd0);
                @(negedge clk);
                check("t1_avail_after", {31'h0, sys_if.rx_avail}, 32'd1);
                check("t1_data", {24'h0, sys_if.rx_data}, 32'hA5);
                check("t1_count", {27'h0, sys_if.rx_count}, 32'd1);
            end
        join
        idle(10);
        pop_one();
        check("t1_avail_pop", {31'h0, sys_if.rx_avail}, 32'd0);
        check_status("t1");

        // Short low pulse is rejected as a glitch
        rxd = 1'b0;
        repeat (10) @(negedge clk);
        idle(200);
        check("t3_avail", {31'h0, sys_if.rx_avail}, 32'd0);
        check_status("t3");

        // Random bytes with a randomly pacing consumer
        mon_en = 1'b1;
        for (int i = 0; i < 20; i++) begin
            send_frame(8'($urandom_range(0, 255)), 1'b1, -1);
            idle($urandom_range(1, 30));
        end
        drain("rand");
        check_status("rand");

        // Fill past capacity with no pops
        for (int i = 0; i <= DEPTH; i++) begin
            send_frame(8'(i), 1'b1, -1);
            idle(2);
        end
        check_status("t2");
        check("t2_head", {24'h0, sys_if.rx_data}, {24'h0, model_q[0]});
        clear_errors();
        check_status("t2_clr");

        // Full FIFO with a pop coinciding with the push
        fork
            send_frame(8'h7E, 1'b1, -1);
            begin
                @(negedge clk);
                repeat (STOP_C) @(negedge clk);
                ack_req = 1'b1;
                @(negedge clk);
                ack_req = 1'b0;
            end
        join
        idle(5);
        check_status("t5");
        check("t5_tail", {24'h0, model_q[DEPTH-1]}, 32'h7E);
        drain("t5");

        // Bad stop bit, long break, then a good byte
        send_frame(8'h3C, 1'b0, -1);
        check_status("t4_err");
        clear_errors();
        repeat (2 * DIV) @(negedge clk);
        check_status("t4_break");
        idle(20);
        send_frame(8'h55, 1'b1, -1);
        idle(5);
        check_status("t4_after");
        drain("t4");

        // Reset in the middle of a frame clears FIFO and partial byte
        send_frame(8'h11, 1'b1, -1);
        idle(5);
        @(negedge clk);
        for (int c = 0; c < 5 * DIV; c++) begin
            rxd = (c < DIV) ? 1'b0 : 1'b1;
            @(negedge clk);
        end
        rst = 1'b0;
        model_q.delete();
        exp_frame_err = 1'b0;
        exp_overrun   = 1'b0;
        repeat (3) @(negedge clk);
        check("t6_rst_avail", {31'h0, sys_if.rx_avail}, 32'd0);
        rst = 1'b1;
        idle(50);
        send_frame(8'h81, 1'b1, -1);
        idle(5);
        check_status("t6");
        check("t6_head", {24'h0, sys_if.rx_data}, 32'h81);
        drain("t6");

`ifdef UART_RX_MAJORITY_EN
        // One-cycle low glitch at the bit-2 centre is outvoted
        send_frame(8'hFF, 1'b1, 3 * DIV + HALF);
        idle(5);
        check_status("maj");
        drain("maj");
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Safety net against a hung run.
    initial begin
        #5ms;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
UART receive front end that feeds `system` from the `uart_rxd` line.
- Synchronises the serial input and recovers 8N1 frames with a mid-bit sampling counter.
- Pushes received bytes into a first-word-fall-through FIFO.
- The system core pops bytes at its own pace; framing and overrun errors are reported as sticky flags.

Parameters:
- clk_freq, 50000000, system clock frequency in Hz
- uart_baud_rate, 1152000, line baud rate
- fifo_depth, 16, FIFO entries; power of two, minimum 2

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  reset, asynchronous, active-low
- uart_rxd  in  1  serial input, idle high, asynchronous to clk
- rx_data  out  8  byte at FIFO head; valid while rx_avail=1
- rx_avail  out  1  FIFO not empty
- rx_ack  in  1  pop head this cycle; ignored when rx_avail=0
- rx_count  out  $clog2(fifo_depth)+1  bytes currently held
- frame_err  out  1  sticky: stop bit sampled low
- overrun  out  1  sticky: byte completed while FIFO full and no pop
- err_clr  in  1  clears frame_err and overrun

Behaviour:
- Reset (rst=0, asynchronous):
  - FIFO empty: rx_avail=0, rx_count=0, rx_data=0.
  - frame_err=0, overrun=0.
  - FSM in IDLE; synchroniser flops preset to 1.
  - Reset mid-frame discards the partial byte and leaves FIFO contents cleared.
- Divisor arithmetic:
  - DIV = clk_freq/uart_baud_rate, integer truncation.
  - HALF = DIV/2.
  - Bit counter is $clog2(DIV) bits wide and counts 0..DIV-1.
- Input path: two-flop synchroniser; rxd_s is the second flop. FSM sees the line 2 cycles late.
- FSM states and transitions:
  - IDLE: rxd_s=0 → START, counter=0.
  - START: at counter=HALF-1, sample rxd_s.
    - 1 → IDLE (glitch reject, no flag).
    - 0 → DATA with counter=0 and bit index=0.
  - DATA: at counter=DIV-1, sample rxd_s, shift in LSB first, counter=0.
    - After the 8th bit → STOP.
  - STOP: at counter=DIV-1, sample rxd_s.
    - 1: push byte, then IDLE.
    - 0: set frame_err, drop byte, then BREAK.
  - BREAK: wait for rxd_s=1, then IDLE. A held-low line produces exactly one frame_err.
- Sampling points: each sample lands nominally mid-bit, i.e. HALF + k·DIV cycles after the synchronised falling edge.
- FIFO:
  - Storage is a register array with wrapping read and write pointers of $clog2(fifo_depth) bits.
  - rx_count is a separate occupancy counter.
  - Push at the stop sample; rx_avail, rx_data and rx_count update on the next edge. Latency is 1 cycle from stop sample to visible data.
  - Pop: rx_ack=1 with rx_avail=1 advances the read pointer on that edge.
  - Push and pop in the same cycle: both happen, rx_count unchanged. When empty, the pushed byte becomes the head.
  - Push when full with no pop: byte dropped, overrun set, contents unchanged.
  - Push when full with a pop in the same cycle: accepted, no overrun.
  - Pointer wrap from fifo_depth-1 to 0 is seamless.
- Error flags:
  - frame_err and overrun stay set until err_clr=1.
  - A set event in the same cycle as err_clr wins, so the flag stays 1.

Optional Feature:
Macro `UART_RX_MAJORITY_EN`.
- Defined:
  - Each START, DATA and STOP sample is the 2-of-3 majority of rxd_s at counter positions target-1, target and target+1.
  - The decision is taken at target+1, and the next bit counter starts from there.
  - Requires DIV ≥ 4.
- Undefined: single sample at the target position; no extra flops.
- FIFO and flag behaviour are identical in both builds.

Test Plan:
All scenarios use the defaults, so DIV=43 and HALF=21; 1 bit = 860 ns at 20 ns clock.
1. Reset, then send 0xA5 8N1 → rx_avail rises 1 cycle after the stop sample; rx_data=0xA5, rx_count=1. Pulse rx_ack → rx_avail=0, rx_count=0.
2. Send 17 bytes 0x00..0x10 with no pops → rx_count=16, overrun=1. Popping returns 0x00..0x0F in order; 0x10 is lost.
3. Drive uart_rxd low for 200 ns (10 cycles), then high → no byte pushed, frame_err=0, FSM back in IDLE.
4. Send 0x3C with the stop bit forced low, hold the line low for 2 bit times, then send 0x55 → frame_err=1 exactly once, FIFO holds only 0x55. err_clr → frame_err=0.
5. With the FIFO full, assert rx_ack in the stop-sample cycle of an incoming 0x7E → no overrun, rx_count stays 16, 0x7E is the last entry.
6. Assert rst low mid-byte (after bit 3), release, then send 0x81 → FIFO holds only 0x81. With `UART_RX_MAJORITY_EN`, a 1-cycle low glitch at the bit-2 centre of 0xFF still yields 0xFF.
